// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the latched request.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic                  write;
    } apb_req_t;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a requester and the register-file completer.
interface apb_slave_regfile_if;
    import apb_pkg::*;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_DATA_W-1:0] pwdata;
    logic [APB_STRB_W-1:0] pstrb;
    logic [APB_DATA_W-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_reg_bank.sv
// Purpose: NUM_REGS-1 read/write words with per-byte write enables.
// Latency: write lands on the clock edge with we=1; read is combinational.
// Backpressure: none, always accepts.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter  int NUM_REGS = 8,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [APB_STRB_W-1:0] wstrb,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    localparam int NUM_RW = NUM_REGS - 1;

    logic [APB_DATA_W-1:0] regs [NUM_RW];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (widx == IDX_W'(i)) begin
                    for (int b = 0; b < APB_STRB_W; b++) begin
                        if (wstrb[b]) begin
                            regs[i][8*b +: 8] <= wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // The top index belongs to the transfer counter, so it reads as zero here.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// Purpose: APB completer with a strobed register bank and a read-only transfer counter.
// Latency: SETUP cycle, then pready in the (WAIT_CYCLES+1)th ACCESS cycle.
// Backpressure: holds pready low for WAIT_CYCLES; psel drop in ACCESS aborts the transfer.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                pclk,
    input  logic                preset,
    apb_slave_regfile_if.slave  apb
);

    localparam int              IDX_W   = $clog2(NUM_REGS);
    localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS - 1);

    apb_state_t            state;
    apb_req_t              req_q;
    logic [3:0]            wait_cnt;
    logic [APB_DATA_W-1:0] xfer_cnt;

    logic [IDX_W-1:0]      idx;
    logic                  err;
    logic                  rdy;
    logic                  done;
    logic [APB_DATA_W-1:0] bank_rdata;
    logic [APB_DATA_W-1:0] rd_val;

    assign idx  = req_q.addr[IDX_W+1:2];
    assign err  = (req_q.addr[1:0] != 2'b00)
               || (req_q.addr >= APB_ADDR_W'(NUM_REGS * 4))
               || (req_q.write && (idx == CNT_IDX));
    assign rdy  = (state == ACCESS) && (wait_cnt == 4'd0);
    assign done = rdy && apb.psel && apb.penable;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            req_q    <= '0;
            wait_cnt <= '0;
            xfer_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (apb.psel && !apb.penable) begin
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    req_q.addr  <= apb.paddr;
                    req_q.wdata <= apb.pwdata;
                    req_q.strb  <= apb.pstrb;
                    req_q.write <= apb.pwrite;
                    wait_cnt    <= 4'(WAIT_CYCLES);
                    state       <= ACCESS;
                end
                ACCESS: begin
                    if (!apb.psel) begin
                        state <= IDLE;
                    end else begin
                        if (wait_cnt != 4'd0) begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                        if (done) begin
                            state    <= IDLE;
                            xfer_cnt <= xfer_cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .pclk   (pclk),
        .preset (preset),
        .we     (done && req_q.write && !err),
        .widx   (idx),
        .wdata  (req_q.wdata),
        .wstrb  (req_q.strb),
        .ridx   (idx),
        .rdata  (bank_rdata)
    );

    // Outputs decode only flops, so reset forces them low without waiting for a clock.
    assign rd_val      = (idx == CNT_IDX) ? xfer_cnt : bank_rdata;
    assign apb.pready  = rdy;
    assign apb.pslverr = rdy && err;
    assign apb.prdata  = (rdy && !req_q.write && !err) ? rd_val : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench: a vector table on the default instance plus abort, reset and back-to-back sequences.
module tb_apb_slave_regfile;

    logic        pclk;
    logic        preset;
    logic        use0;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic [31:0] prdata_m;
    logic        pready_m;
    logic        pslverr_m;

    int n_cmp;
    int n_bad;
    int n_done1;
    int n_done0;

    apb_slave_regfile_if b1 ();
    apb_slave_regfile_if b0 ();

    assign b1.psel    = psel && !use0;
    assign b1.penable = penable;
    assign b1.pwrite  = pwrite;
    assign b1.paddr   = paddr;
    assign b1.pwdata  = pwdata;
    assign b1.pstrb   = pstrb;
    assign b0.psel    = psel && use0;
    assign b0.penable = penable;
    assign b0.pwrite  = pwrite;
    assign b0.paddr   = paddr;
    assign b0.pwdata  = pwdata;
    assign b0.pstrb   = pstrb;

    assign prdata_m  = use0 ? b0.prdata  : b1.prdata;
    assign pready_m  = use0 ? b0.pready  : b1.pready;
    assign pslverr_m = use0 ? b0.pslverr : b1.pslverr;

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(1)) dut (
        .pclk   (pclk),
        .preset (preset),
        .apb    (b1.slave)
    );

    apb_slave_regfile #(.NUM_REGS(8), .WAIT_CYCLES(0)) dut0 (
        .pclk   (pclk),
        .preset (preset),
        .apb    (b0.slave)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // One transfer: setup phase, then penable high until pready. The first
    // enabled cycle is the completer's SETUP cycle, so acc counts ACCESS cycles.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rd, output logic er,
                        output int acc);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        @(posedge pclk); #1;
        penable = 1'b1;
        acc = -1;
        rd  = '0;
        er  = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge pclk);
            if (pready_m) begin
                rd  = prdata_m;
                er  = pslverr_m;
                acc = n - 1;
                break;
            end
            chk("wait_pslverr", {31'd0, pslverr_m}, 32'd0);
            chk("wait_prdata", prdata_m, 32'd0);
            @(posedge pclk); #1;
        end
        if (acc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL xfer_timeout addr %h: got no pready in 40 cycles, required pready", addr);
        end else begin
            @(posedge pclk); #1;
            if (use0) n_done0++;
            else      n_done1++;
        end
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        vt [16];
    logic [31:0] rd;
    logic        er;
    int          acc;
    int          exp_cnt;

    initial begin
        n_cmp = 0; n_bad = 0; n_done1 = 0; n_done0 = 0;
        preset = 1'b1; use0 = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        vt[0]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'h0,        1'b0};
        vt[1]  = '{1'b1, 32'h04,       32'h1234ABCD, 4'hF, 32'h0,        1'b0};
        vt[2]  = '{1'b0, 32'h04,       32'h0,        4'h0, 32'h1234ABCD, 1'b0};
        vt[3]  = '{1'b1, 32'h08,       32'hFFFFFFFF, 4'hF, 32'h0,        1'b0};
        vt[4]  = '{1'b1, 32'h08,       32'h00000000, 4'h2, 32'h0,        1'b0};
        vt[5]  = '{1'b0, 32'h08,       32'h0,        4'h0, 32'hFFFF00FF, 1'b0};
        vt[6]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h0,        1'b1};
        vt[7]  = '{1'b0, 32'h06,       32'h0,        4'h0, 32'h0,        1'b1};
        vt[8]  = '{1'b1, 32'h1C,       32'h00000055, 4'hF, 32'h0,        1'b1};
        vt[9]  = '{1'b0, 32'h1C,       32'h0,        4'h0, 32'd9,        1'b0};
        vt[10] = '{1'b1, 32'h00,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
        vt[11] = '{1'b0, 32'h00,       32'h0,        4'h0, 32'h00BB00DD, 1'b0};
        vt[12] = '{1'b1, 32'h18,       32'h11223344, 4'hF, 32'h0,        1'b0};
        vt[13] = '{1'b0, 32'h18,       32'h0,        4'h0, 32'h11223344, 1'b0};
        vt[14] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};
        vt[15] = '{1'b0, 32'h1C,       32'h0,        4'h0, 32'd15,       1'b0};

        #2;
        chk("rst_pready",  {31'd0, b1.pready},  32'd0);
        chk("rst_pslverr", {31'd0, b1.pslverr}, 32'd0);
        chk("rst_prdata",  b1.prdata,           32'd0);
        chk("rst_pready0", {31'd0, b0.pready},  32'd0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            xfer(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb, rd, er, acc);
            chk($sformatf("vec%0d_prdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_pslverr", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            chk($sformatf("vec%0d_acc_cycle", i), acc, 32'd2);
        end

        // Abort: psel drops while the write is still in its wait state.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        chk("abort_wait_pready", {31'd0, pready_m}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(1'b0, 32'h0C, 32'h0, 4'h0, rd, er, acc);
        chk("abort_reg_0c", rd, 32'h0);
        exp_cnt = n_done1;
        xfer(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, acc);
        chk("abort_counter", rd, exp_cnt);

        // Reset lands while the write to 0x10 is presenting pready.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk); #1 penable = 1'b1;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("rstmid_pre_pready", {31'd0, pready_m}, 32'd1);
        #1 preset = 1'b1;
        #1;
        chk("rstmid_pready",  {31'd0, pready_m},  32'd0);
        chk("rstmid_pslverr", {31'd0, pslverr_m}, 32'd0);
        chk("rstmid_prdata",  prdata_m,           32'd0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1 preset = 1'b0;
        n_done1 = 0; n_done0 = 0;
        xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, acc);
        chk("rstmid_reg_10", rd, 32'h0);
        xfer(1'b0, 32'h04, 32'h0, 4'h0, rd, er, acc);
        chk("rstmid_reg_04", rd, 32'h0);
        exp_cnt = n_done1;
        xfer(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, acc);
        chk("rstmid_counter", rd, exp_cnt);

        // Back-to-back on the zero-wait instance: no idle cycle between transfers.
        use0 = 1'b1;
        xfer(1'b1, 32'h00, 32'h5A5AA5A5, 4'hF, rd, er, acc);
        chk("b2b_wr_acc_cycle", acc, 32'd1);
        chk("b2b_wr_pslverr", {31'd0, er}, 32'd0);
        xfer(1'b0, 32'h00, 32'h0, 4'h0, rd, er, acc);
        chk("b2b_rd_acc_cycle", acc, 32'd1);
        chk("b2b_rd_prdata", rd, 32'h5A5AA5A5);
        exp_cnt = n_done0;
        xfer(1'b0, 32'h1C, 32'h0, 4'h0, rd, er, acc);
        chk("b2b_counter", rd, exp_cnt);
        use0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter NUM_REGS, default 8: number of 32-bit word registers (power of 2, at least 2).
REQ-002 Parameter WAIT_CYCLES, default 1: wait states inserted per transfer (0..15).
REQ-003 pclk  input  1  single clock, all state on rising edge.
REQ-004 preset  input  1  asynchronous, active-high reset.
REQ-005 psel  input  1  completer select.
REQ-006 penable  input  1  access-phase indicator.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  32  byte address.
REQ-009 pwdata  input  32  write data.
REQ-010 pstrb  input  4  byte-lane write strobes.
REQ-011 prdata  output  32  read data.
REQ-012 pready  output  1  transfer-complete indicator.
REQ-013 pslverr  output  1  transfer error.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP and ACCESS.
REQ-015 IDLE -> SETUP when psel=1 and penable=0; otherwise stay in IDLE. penable=1 seen in IDLE is ignored.
REQ-016 SETUP SHALL latch paddr, pwrite, pwdata and pstrb, load the wait counter with WAIT_CYCLES, then go to ACCESS unconditionally.
REQ-017 In ACCESS, pready SHALL be 1 exactly when the wait counter is 0; the counter decrements each cycle while non-zero.
REQ-018 ACCESS -> IDLE on the edge where psel=1, penable=1 and pready=1. That edge completes the transfer.
REQ-019 ACCESS -> IDLE with no register update and no counter increment if psel=0 (aborted transfer).
REQ-020 Transfer latency: pready SHALL rise in the (WAIT_CYCLES+1)th access-phase cycle. With WAIT_CYCLES=0 this is the first access cycle.
REQ-021 Register index is paddr[log2(NUM_REGS)+1:2]. Registers 0..NUM_REGS-2 are RW. Register NUM_REGS-1 is the read-only transfer counter.
REQ-022 An error transfer is any of: paddr[1:0]!=0; paddr >= NUM_REGS*4; a write to the counter register.
REQ-023 A completing write with no error SHALL update only the byte lanes whose pstrb bit is 1.
REQ-024 An error transfer SHALL modify no register and SHALL drive pslverr=1 while pready=1.
REQ-025 pslverr SHALL be 0 whenever pready=0.
REQ-026 prdata SHALL hold the addressed register value while pready=1 on a non-error read, and 0 at all other times.
REQ-027 The transfer counter (32 bits) SHALL increment on every completed transfer, error or not, and wrap from 0xFFFFFFFF to 0.
REQ-028 A read of the counter register returns the value before that transfer's increment.
REQ-029 Back-to-back transfers are legal: a SETUP may immediately follow the completing ACCESS edge.

Reset
REQ-030 On preset=1 the FSM SHALL go to IDLE immediately, asynchronously.
REQ-031 On preset=1 all registers, the wait counter and the transfer counter SHALL clear to 0, and prdata, pready and pslverr SHALL be 0.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no register write.

Structure
REQ-033 Shared package apb_pkg SHALL hold: the state enum (IDLE/SETUP/ACCESS), APB_ADDR_W=32, APB_DATA_W=32 and APB_STRB_W=4.
REQ-034 The register bank with byte-strobe write SHALL be the single sub-module apb_reg_bank. The FSM, wait counter and error decode live in the top module.

Verification
REQ-035 Write 0x1234ABCD to 0x04 with pstrb=0xF, then read 0x04 -> prdata=0x1234ABCD, pslverr=0; pready rises in access cycle 2 (default WAIT_CYCLES=1).
REQ-036 Write 0xFFFFFFFF to 0x08, then write 0x00000000 to 0x08 with pstrb=0x2, then read 0x08 -> 0xFFFF00FF.
REQ-037 Read 0x20, read 0x06, and write 0x1C -> each returns pslverr=1 with pready=1. A subsequent read of 0x1C returns the number of prior completed transfers.
REQ-038 Drop psel during the wait state of a write of 0xDEADBEEF to 0x0C -> read 0x0C returns 0; counter is not incremented.
REQ-039 Assert preset during ACCESS of a write to 0x10 -> pready=0 immediately; read 0x10 returns 0.
REQ-040 Back-to-back: write 0x0 then read 0x0 with no IDLE cycle between, with WAIT_CYCLES=0 -> each pready in the first access cycle and the read returns the written data.
